// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     CLEAR,
  input  logic                     PUSH,
  input  logic [DATA_WIDTH-1:0]    DATA,
  input  logic                     POP,
  output logic [DATA_WIDTH-1:0]    DATA_OUT,
  output logic                     DATA_VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic psh, input logic pp);
    case ({psh, pp})
      2'b10:   next_count = cnt + CW'(1);
      2'b01:   next_count = cnt - CW'(1);
      default: next_count = cnt;
    endcase
  endfunction

  assign FULL         = (COUNT == DEPTH_C);
  assign EMPTY        = (COUNT == '0);
  assign ALMOST_FULL  = (COUNT >= AFULL_C);
  assign ALMOST_EMPTY = (COUNT <= AEMPTY_C);

  // A pop frees a slot in the same cycle, so a full FIFO can accept push+pop.
  assign pop_acc  = POP & ~EMPTY;
  assign push_acc = PUSH & (~FULL | pop_acc);

  // Storage: no reset, write suppressed by flush
  always_ff @(posedge clk) begin
    if (push_acc && !CLEAR)
      mem[wr_ptr] <= DATA;
  end

  // Control and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      COUNT      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else if (CLEAR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      COUNT      <= '0;
      DATA_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else begin
      DATA_VALID <= pop_acc;
      if (push_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc) begin
        DATA_OUT <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      COUNT <= next_count(COUNT, push_acc, pop_acc);
      if (PUSH && !push_acc)
        OVERFLOW <= 1'b1;
      if (POP && EMPTY)
        UNDERFLOW <= 1'b1;
    end
  end

endmodule
